tri_xor_accum_arb: RTL



---
 rtl/tri_xor_accum_arb.sv | 119 +++++++++++
 1 files changed

// File: rtl/tri_xor_accum_arb.sv
// Round-robin arbiter that shares one XOR accumulator among NREQ requesters.
// Each multi-beat packet folds into one result, tagged with the owner's ID.
module tri_xor_accum_arb #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_val,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_rdy,
    output logic                  res_val,
    output logic [2:0]            res_id,
    output logic [WIDTH-1:0]      res_data,
    output logic                  res_err,
    input  logic                  res_rdy
);
    localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     ptr, gnt, pick, gnt_inc;
    logic              any_req;
    logic [WIDTH-1:0]  acc, beat_data;
    logic [3:0]        beat_cnt;
    logic              err;
    logic              beat_ok, beat_last, close_pkt;
    logic [2*NREQ-1:0] rot;
    logic [WIDTH-1:0]  beats [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign beats[g] = req_data[g*WIDTH +: WIDTH];
    end

    // Rotating the request vector by ptr turns the search into a plain first-set scan.
    assign any_req = |req_val;
    assign rot     = {req_val, req_val} >> ptr;

    always_comb begin
        int s;
        logic found;
        pick  = ptr;
        found = 1'b0;
        s     = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                s = int'(ptr) + i;
                if (s >= NREQ) s = s - NREQ;
                pick = IW'(s);
            end
        end
    end

    assign beat_data = beats[gnt];
    assign beat_ok   = (state == ACCUM) && req_val[gnt];
    assign beat_last = req_last[gnt];
    assign close_pkt = beat_ok && (beat_last || beat_cnt == 4'd15);
    assign gnt_inc   = (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)   state_nxt = ACCUM;
            ACCUM:   if (close_pkt) state_nxt = DONE;
            DONE:    if (res_rdy)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            gnt      <= '0;
            acc      <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    gnt      <= pick;
                    acc      <= '0;
                    beat_cnt <= '0;
                    err      <= 1'b0;
                end
                ACCUM: if (beat_ok) begin
                    acc      <= acc ^ beat_data;
                    beat_cnt <= beat_cnt + 4'd1;
                    if (close_pkt) err <= ~beat_last;
                end
                DONE: if (res_rdy) ptr <= gnt_inc;
                default: ;
            endcase
        end
    end

    // Outputs decode only state and registered values, never the live inputs.
    always_comb begin
        req_rdy  = '0;
        res_val  = 1'b0;
        res_id   = '0;
        res_data = '0;
        res_err  = 1'b0;
        if (state == ACCUM) req_rdy[gnt] = 1'b1;
        if (state == DONE) begin
            res_val  = 1'b1;
            res_id   = 3'(gnt);
            res_data = acc;
            res_err  = err;
        end
    end
endmodule
